// File: rtl/oled_spi_rx.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : oled_spi_rx                                                   |
// | Purpose  : Receive side of an SSD1306 4-wire SPI link. Oversamples the   |
// |            pins, deserialises command/data bytes (MSB first, sclk rise), |
// |            decodes the SSD1306 command subset and turns data bytes into  |
// |            framebuffer writes.                                           |
// | Ports    : clk, rst_n          system clock, async active-low reset      |
// |            i_sclk/i_sdin/i_cs/i_dc  SPI pins (sclk idles high, cs low)   |
// |            i_res_n             display reset pin, active low             |
// |            o_byte_valid/o_byte/o_byte_dc   received byte strobe          |
// |            o_fb_we/o_fb_addr/o_fb_data     framebuffer write port        |
// |            o_display_on/o_contrast/o_charge_pump   decoded settings      |
// |            o_frame_err         only with OLED_RX_FRAME_ERR_EN defined    |
// | Options  : OLED_RX_FRAME_ERR_EN adds a sticky partial-byte error flag.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module oled_spi_rx #(
  parameter int COLS   = 128,
  parameter int PAGES  = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_sclk,
  input  logic              i_sdin,
  input  logic              i_cs,
  input  logic              i_dc,
  input  logic              i_res_n,
  output logic              o_byte_valid,
  output logic [7:0]        o_byte,
  output logic              o_byte_dc,
  output logic              o_fb_we,
  output logic [ADDR_W-1:0] o_fb_addr,
  output logic [7:0]        o_fb_data,
  output logic              o_display_on,
  output logic [7:0]        o_contrast,
  output logic              o_charge_pump
`ifdef OLED_RX_FRAME_ERR_EN
  ,output logic             o_frame_err
`endif
);

  localparam int C_COL_W  = (COLS  > 1) ? $clog2(COLS)  : 1;
  localparam int C_PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam logic [C_COL_W-1:0]  C_COL_MAX  = C_COL_W'(COLS - 1);
  localparam logic [C_PAGE_W-1:0] C_PAGE_MAX = C_PAGE_W'(PAGES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARG1 = 2'd1,
    ST_ARG2 = 2'd2
  } state_t;

  // ---------------------------------------------------------------- front end
  logic r_sclk_meta, r_sclk_sync, r_sclk_prev;
  logic r_sdin_meta, r_sdin_sync;
  logic r_cs_meta,   r_cs_sync;
  logic r_dc_meta,   r_dc_sync;
  logic r_res_meta,  r_res_sync;

  // Synchronisers reset to the idle pin levels so no spurious edge is seen
  // leaving reset. The display reset sync starts asserted, which simply holds
  // the receiver in reset for two extra cycles after rst_n releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_meta <= 1'b1;
      r_sclk_sync <= 1'b1;
      r_sclk_prev <= 1'b1;
      r_sdin_meta <= 1'b0;
      r_sdin_sync <= 1'b0;
      r_cs_meta   <= 1'b1;
      r_cs_sync   <= 1'b1;
      r_dc_meta   <= 1'b0;
      r_dc_sync   <= 1'b0;
      r_res_meta  <= 1'b0;
      r_res_sync  <= 1'b0;
    end else begin
      r_sclk_meta <= i_sclk;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_prev <= r_sclk_sync;
      r_sdin_meta <= i_sdin;
      r_sdin_sync <= r_sdin_meta;
      r_cs_meta   <= i_cs;
      r_cs_sync   <= r_cs_meta;
      r_dc_meta   <= i_dc;
      r_dc_sync   <= r_dc_meta;
      r_res_meta  <= i_res_n;
      r_res_sync  <= r_res_meta;
    end
  end

  logic w_srst;
  logic w_sclk_rise;
  logic w_byte_done;

  assign w_srst      = ~r_res_sync;
  assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;

  // ------------------------------------------------------------- deserialiser
  logic [6:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_byte_valid;
  logic [7:0] r_byte;
  logic       r_byte_dc;

  // The bit counter can only be 7 if cs was low on the previous rise, so a
  // final edge coinciding with cs going high still completes the byte.
  assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_byte_valid <= 1'b0;
      r_byte       <= '0;
      r_byte_dc    <= 1'b0;
    end else if (w_srst) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_byte_valid <= 1'b0;
      r_byte       <= '0;
      r_byte_dc    <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      if (w_byte_done) begin
        r_byte       <= {r_shift, r_sdin_sync};
        r_byte_dc    <= r_dc_sync;
        r_byte_valid <= 1'b1;
        r_shift      <= '0;
        r_bit_cnt    <= '0;
      end else if (r_cs_sync) begin
        r_shift      <= '0;
        r_bit_cnt    <= '0;
      end else if (w_sclk_rise) begin
        r_shift      <= {r_shift[5:0], r_sdin_sync};
        r_bit_cnt    <= r_bit_cnt + 3'd1;
      end
    end
  end

`ifdef OLED_RX_FRAME_ERR_EN
  logic r_cs_prev;
  logic r_frame_err;

  // Flag cs deasserting with a partial byte in the shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_prev   <= 1'b1;
      r_frame_err <= 1'b0;
    end else if (w_srst) begin
      r_cs_prev   <= 1'b1;
      r_frame_err <= 1'b0;
    end else begin
      r_cs_prev <= r_cs_sync;
      if (r_cs_sync && !r_cs_prev && (r_bit_cnt != 3'd0) && !w_byte_done)
        r_frame_err <= 1'b1;
    end
  end

  assign o_frame_err = r_frame_err;
`endif

  // ------------------------------------------------------------- decoder FSM
  state_t r_state, w_state_next;
  logic   w_takes_arg;
  logic   w_is_cmd, w_is_arg1, w_is_arg2, w_is_data;
  logic [7:0] r_cmd;

  always_comb begin
    w_takes_arg = 1'b0;
    case (r_byte)
      8'h81, 8'h8D, 8'h20, 8'h21, 8'h22,
      8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDB: w_takes_arg = 1'b1;
      default:                           w_takes_arg = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_state <= ST_IDLE;
    else if (w_srst) r_state <= ST_IDLE;
    else             r_state <= w_state_next;
  end

  // A data byte always wins: it abandons any half-received command.
  always_comb begin
    w_state_next = r_state;
    w_is_cmd     = 1'b0;
    w_is_arg1    = 1'b0;
    w_is_arg2    = 1'b0;
    w_is_data    = 1'b0;
    if (r_byte_valid) begin
      if (r_byte_dc) begin
        w_is_data    = 1'b1;
        w_state_next = ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            w_is_cmd = 1'b1;
            if (w_takes_arg) w_state_next = ST_ARG1;
          end
          ST_ARG1: begin
            w_is_arg1    = 1'b1;
            w_state_next = ((r_cmd == 8'h21) || (r_cmd == 8'h22)) ? ST_ARG2 : ST_IDLE;
          end
          ST_ARG2: begin
            w_is_arg2    = 1'b1;
            w_state_next = ST_IDLE;
          end
          default: w_state_next = ST_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- datapath
  logic [C_COL_W-1:0]  r_col, r_col_start, r_col_end;
  logic [C_PAGE_W-1:0] r_page, r_page_start, r_page_end;
  logic [1:0]          r_mode;
  logic                r_display_on, r_charge_pump;
  logic [7:0]          r_contrast;
  logic                r_fb_we;
  logic [ADDR_W-1:0]   r_fb_addr;
  logic [7:0]          r_fb_data;

  logic [C_COL_W-1:0]  w_col_inc, w_col_adv;
  logic [C_PAGE_W-1:0] w_page_inc, w_page_adv;
  logic [ADDR_W-1:0]   w_fb_addr;

  // "Advance": end of window returns to start, otherwise step modulo size.
  // A start greater than end therefore wraps through zero.
  assign w_col_inc  = (r_col == C_COL_MAX) ? '0 : r_col + 1'b1;
  assign w_col_adv  = (r_col == r_col_end) ? r_col_start : w_col_inc;
  assign w_page_inc = (r_page == C_PAGE_MAX) ? '0 : r_page + 1'b1;
  assign w_page_adv = (r_page == r_page_end) ? r_page_start : w_page_inc;
  assign w_fb_addr  = ADDR_W'(r_page) * ADDR_W'(COLS) + ADDR_W'(r_col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd         <= '0;
      r_col         <= '0;
      r_col_start   <= '0;
      r_col_end     <= C_COL_MAX;
      r_page        <= '0;
      r_page_start  <= '0;
      r_page_end    <= C_PAGE_MAX;
      r_mode        <= 2'b10;
      r_display_on  <= 1'b0;
      r_charge_pump <= 1'b0;
      r_contrast    <= 8'h7F;
      r_fb_we       <= 1'b0;
      r_fb_addr     <= '0;
      r_fb_data     <= '0;
    end else if (w_srst) begin
      r_cmd         <= '0;
      r_col         <= '0;
      r_col_start   <= '0;
      r_col_end     <= C_COL_MAX;
      r_page        <= '0;
      r_page_start  <= '0;
      r_page_end    <= C_PAGE_MAX;
      r_mode        <= 2'b10;
      r_display_on  <= 1'b0;
      r_charge_pump <= 1'b0;
      r_contrast    <= 8'h7F;
      r_fb_we       <= 1'b0;
      r_fb_addr     <= '0;
      r_fb_data     <= '0;
    end else begin
      r_fb_we <= 1'b0;

      if (w_is_cmd) begin
        r_cmd <= r_byte;
        if (r_byte == 8'hAE) r_display_on <= 1'b0;
        if (r_byte == 8'hAF) r_display_on <= 1'b1;
      end

      if (w_is_arg1) begin
        case (r_cmd)
          8'h81: r_contrast    <= r_byte;
          8'h8D: r_charge_pump <= r_byte[2];
          8'h20: r_mode        <= r_byte[1:0];
          8'h21: begin
            r_col_start <= C_COL_W'(r_byte);
            r_col       <= C_COL_W'(r_byte);
          end
          8'h22: begin
            r_page_start <= C_PAGE_W'(r_byte);
            r_page       <= C_PAGE_W'(r_byte);
          end
          default: ;  // argument of a command we do not model
        endcase
      end

      if (w_is_arg2) begin
        if (r_cmd == 8'h21) r_col_end  <= C_COL_W'(r_byte);
        if (r_cmd == 8'h22) r_page_end <= C_PAGE_W'(r_byte);
      end

      if (w_is_data) begin
        r_fb_we   <= 1'b1;
        r_fb_addr <= w_fb_addr;
        r_fb_data <= r_byte;
        case (r_mode)
          2'b00: begin
            r_col <= w_col_adv;
            if (r_col == r_col_end) r_page <= w_page_adv;
          end
          2'b01: begin
            r_page <= w_page_adv;
            if (r_page == r_page_end) r_col <= w_col_adv;
          end
          default: r_col <= w_col_adv;
        endcase
      end
    end
  end

  assign o_byte_valid  = r_byte_valid;
  assign o_byte        = r_byte;
  assign o_byte_dc     = r_byte_dc;
  assign o_fb_we       = r_fb_we;
  assign o_fb_addr     = r_fb_addr;
  assign o_fb_data     = r_fb_data;
  assign o_display_on  = r_display_on;
  assign o_contrast    = r_contrast;
  assign o_charge_pump = r_charge_pump;

endmodule

`default_nettype wire

// File: tb/tb_oled_spi_rx.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : tb_oled_spi_rx                                                |
// | Purpose  : Self-checking bench for oled_spi_rx. Drives the SPI pins      |
// |            bit by bit and compares the received bytes, framebuffer       |
// |            writes and decoded settings against a behavioural model of    |
// |            the SSD1306 command rules.                                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_oled_spi_rx;

  localparam int COLS   = 128;
  localparam int PAGES  = 8;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b1, sdin = 1'b0, cs = 1'b1, dc = 1'b0, res_n = 1'b1;

  logic              byte_valid, byte_dc, fb_we, display_on, charge_pump;
  logic [7:0]        rx_byte, fb_data, contrast;
  logic [ADDR_W-1:0] fb_addr;
`ifdef OLED_RX_FRAME_ERR_EN
  logic              frame_err;
`endif

  always #5 clk = ~clk;

  oled_spi_rx #(.COLS(COLS), .PAGES(PAGES), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_sclk       (sclk),
    .i_sdin       (sdin),
    .i_cs         (cs),
    .i_dc         (dc),
    .i_res_n      (res_n),
    .o_byte_valid (byte_valid),
    .o_byte       (rx_byte),
    .o_byte_dc    (byte_dc),
    .o_fb_we      (fb_we),
    .o_fb_addr    (fb_addr),
    .o_fb_data    (fb_data),
    .o_display_on (display_on),
    .o_contrast   (contrast),
    .o_charge_pump(charge_pump)
`ifdef OLED_RX_FRAME_ERR_EN
    ,.o_frame_err (frame_err)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ DUT capture
  logic [8:0]  byte_q[$];
  logic [17:0] fb_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid) byte_q.push_back({byte_dc, rx_byte});
      if (fb_we)      fb_q.push_back({fb_addr, fb_data});
    end
  end

  // ------------------------------------------------------ reference model
  int m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_mode, m_need, m_argi;
  logic       m_on, m_cp;
  logic [7:0] m_ct, m_cmd;
  logic [17:0] exp_fb_q[$];

  task automatic m_reset();
    m_col = 0; m_page = 0; m_cs = 0; m_ce = COLS - 1; m_ps = 0; m_pe = PAGES - 1;
    m_mode = 2; m_need = 0; m_argi = 0; m_on = 1'b0; m_cp = 1'b0; m_ct = 8'h7F;
    m_cmd = 8'h00;
  endtask

  function automatic int nxt(input int p, input int s, input int e, input int size);
    return (p == e) ? s : (p + 1) % size;
  endfunction

  task automatic m_feed(input logic d, input logic [7:0] b);
    if (d) begin
      m_need = 0;
      exp_fb_q.push_back({ADDR_W'(m_page * COLS + m_col), b});
      if (m_mode == 0) begin
        if (m_col == m_ce) begin m_col = m_cs; m_page = nxt(m_page, m_ps, m_pe, PAGES); end
        else m_col = (m_col + 1) % COLS;
      end else if (m_mode == 1) begin
        if (m_page == m_pe) begin m_page = m_ps; m_col = nxt(m_col, m_cs, m_ce, COLS); end
        else m_page = (m_page + 1) % PAGES;
      end else begin
        m_col = nxt(m_col, m_cs, m_ce, COLS);
      end
    end else if (m_need > 0) begin
      case (m_cmd)
        8'h81: m_ct = b;
        8'h8D: m_cp = b[2];
        8'h20: m_mode = int'(b[1:0]);
        8'h21: if (m_argi == 0) begin m_cs = b % COLS; m_col = m_cs; end else m_ce = b % COLS;
        8'h22: if (m_argi == 0) begin m_ps = b % PAGES; m_page = m_ps; end else m_pe = b % PAGES;
        default: ;
      endcase
      m_argi++;
      m_need--;
    end else begin
      m_cmd = b;
      m_argi = 0;
      case (b)
        8'hAE: m_on = 1'b0;
        8'hAF: m_on = 1'b1;
        8'h81, 8'h8D, 8'h20, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDB: m_need = 1;
        8'h21, 8'h22: m_need = 2;
        default: m_need = 0;
      endcase
    end
  endtask

  // ------------------------------------------------------------ pin drivers
  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input logic d, input int nbits);
    dc = d;
    for (int i = 7; i > 7 - nbits; i--) begin
      sclk = 1'b0; sdin = b[i]; wclk(2);
      sclk = 1'b1; wclk(2);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d);
    send_bits(b, d, 8);
    m_feed(d, b);
  endtask

  task automatic cs_low();
    cs = 1'b0; wclk(2);
  endtask

  task automatic cs_high();
    wclk(2); cs = 1'b1; wclk(2);
  endtask

  task automatic clear_q();
    byte_q.delete(); fb_q.delete(); exp_fb_q.delete();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_display_on"}, display_on, 1'b0);
    chk({tag, "_contrast"},   contrast,   8'h7F);
    chk({tag, "_charge"},     charge_pump, 1'b0);
    chk({tag, "_byte_valid"}, byte_valid, 1'b0);
    chk({tag, "_byte"},       rx_byte,    8'h00);
    chk({tag, "_fb_we"},      fb_we,      1'b0);
    chk({tag, "_fb_addr"},    fb_addr,    '0);
    chk({tag, "_fb_data"},    fb_data,    8'h00);
`ifdef OLED_RX_FRAME_ERR_EN
    chk({tag, "_frame_err"},  frame_err,  1'b0);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wclk(3); rst_n = 1'b1; wclk(4);
    m_reset(); clear_q();
  endtask

  task automatic compare_fb(input string tag);
    int n;
    chk({tag, "_fb_count"}, fb_q.size(), exp_fb_q.size());
    n = (fb_q.size() < exp_fb_q.size()) ? fb_q.size() : exp_fb_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_fb[%0d]", tag, i), fb_q[i], exp_fb_q[i]);
  endtask

  // ------------------------------------------------------------ init table
  typedef struct {
    logic       dc;
    logic [7:0] b;
    logic       exp_on;
    logic [7:0] exp_ct;
    logic       exp_cp;
  } vec_t;

  vec_t init_tbl[23];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] pool [12];
    logic [7:0] b;
    logic       d;
    int         exp_addr [7];

    init_tbl[0]  = '{1'b0, 8'hAE, 1'b0, 8'h7F, 1'b0};
    init_tbl[1]  = '{1'b0, 8'h81, 1'b0, 8'h7F, 1'b0};
    init_tbl[2]  = '{1'b0, 8'h7F, 1'b0, 8'h7F, 1'b0};
    init_tbl[3]  = '{1'b0, 8'hA6, 1'b0, 8'h7F, 1'b0};
    init_tbl[4]  = '{1'b0, 8'h20, 1'b0, 8'h7F, 1'b0};
    init_tbl[5]  = '{1'b0, 8'h00, 1'b0, 8'h7F, 1'b0};
    init_tbl[6]  = '{1'b0, 8'hC8, 1'b0, 8'h7F, 1'b0};
    init_tbl[7]  = '{1'b0, 8'h40, 1'b0, 8'h7F, 1'b0};
    init_tbl[8]  = '{1'b0, 8'hA1, 1'b0, 8'h7F, 1'b0};
    init_tbl[9]  = '{1'b0, 8'hA8, 1'b0, 8'h7F, 1'b0};
    init_tbl[10] = '{1'b0, 8'h3F, 1'b0, 8'h7F, 1'b0};
    init_tbl[11] = '{1'b0, 8'hD3, 1'b0, 8'h7F, 1'b0};
    init_tbl[12] = '{1'b0, 8'h00, 1'b0, 8'h7F, 1'b0};
    init_tbl[13] = '{1'b0, 8'hD5, 1'b0, 8'h7F, 1'b0};
    init_tbl[14] = '{1'b0, 8'h80, 1'b0, 8'h7F, 1'b0};
    init_tbl[15] = '{1'b0, 8'hD9, 1'b0, 8'h7F, 1'b0};
    init_tbl[16] = '{1'b0, 8'h22, 1'b0, 8'h7F, 1'b0};
    init_tbl[17] = '{1'b0, 8'hDB, 1'b0, 8'h7F, 1'b0};
    init_tbl[18] = '{1'b0, 8'h20, 1'b0, 8'h7F, 1'b0};
    init_tbl[19] = '{1'b0, 8'h8D, 1'b0, 8'h7F, 1'b0};
    init_tbl[20] = '{1'b0, 8'h14, 1'b0, 8'h7F, 1'b1};
    init_tbl[21] = '{1'b0, 8'hA4, 1'b0, 8'h7F, 1'b1};
    init_tbl[22] = '{1'b0, 8'hAF, 1'b1, 8'h7F, 1'b1};

    pool = '{8'hAE, 8'hAF, 8'h81, 8'h8D, 8'h20, 8'h21,
             8'h22, 8'hA8, 8'hA6, 8'hC8, 8'h40, 8'hD5};
    exp_addr = '{266, 267, 268, 394, 395, 396, 266};

    // Reset state, both while held and after release.
    wclk(3);
    check_reset("rst_hold");
    rst_n = 1'b1; wclk(4);
    check_reset("rst_rel");
    m_reset(); clear_q();

    // Init stream, one table record per byte.
    cs_low();
    for (int i = 0; i < 23; i++) begin
      send_byte(init_tbl[i].b, init_tbl[i].dc);
      wclk(6);
      if (byte_q.size() == 0) begin
        chk($sformatf("init_pulse[%0d]", i), 0, 1);
      end else begin
        chk($sformatf("init_byte[%0d]", i), byte_q.pop_front(), {init_tbl[i].dc, init_tbl[i].b});
      end
      chk($sformatf("init_on[%0d]", i), display_on,  init_tbl[i].exp_on);
      chk($sformatf("init_ct[%0d]", i), contrast,    init_tbl[i].exp_ct);
      chk($sformatf("init_cp[%0d]", i), charge_pump, init_tbl[i].exp_cp);
    end
    cs_high();
    chk("init_no_fb", fb_q.size(), 0);
    clear_q();

    // Full window, horizontal mode: 1025 writes wrap to address 0.
    cs_low();
    send_byte(8'h21, 0); send_byte(8'h00, 0); send_byte(8'h7F, 0);
    send_byte(8'h22, 0); send_byte(8'h00, 0); send_byte(8'h07, 0);
    for (int i = 0; i < 1025; i++) send_byte(8'($urandom), 1);
    cs_high(); wclk(8);
    chk("full_pulses", byte_q.size(), 1031);
    compare_fb("full");
    if (fb_q.size() == 1025) begin
      chk("full_addr1023", fb_q[1023][17:8], 1023);
      chk("full_addr_wrap", fb_q[1024][17:8], 0);
    end

    // Page mode from reset: wraps within page 0.
    do_reset();
    cs_low();
    for (int i = 0; i < 130; i++) send_byte(8'($urandom), 1);
    cs_high(); wclk(8);
    compare_fb("page");
    if (fb_q.size() == 130) begin
      chk("page_addr127", fb_q[127][17:8], 127);
      chk("page_wrap0",   fb_q[128][17:8], 0);
      chk("page_wrap1",   fb_q[129][17:8], 1);
    end
    clear_q();

    // Horizontal mode inside a small window.
    cs_low();
    send_byte(8'h20, 0); send_byte(8'h00, 0);
    send_byte(8'h21, 0); send_byte(8'h0A, 0); send_byte(8'h0C, 0);
    send_byte(8'h22, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
    for (int i = 0; i < 7; i++) send_byte(8'(8'h10 + i), 1);
    cs_high(); wclk(8);
    compare_fb("win");
    chk("win_count", fb_q.size(), 7);
    for (int i = 0; i < 7 && i < fb_q.size(); i++)
      chk($sformatf("win_addr[%0d]", i), fb_q[i][17:8], exp_addr[i]);
    clear_q();

    // Fragment of 5 bits between full bytes is dropped.
    cs_low(); send_byte(8'hAF, 0); cs_high();
    cs_low(); send_bits(8'hFF, 0, 5); cs_high();
    cs_low(); send_byte(8'hAE, 0); cs_high();
    wclk(6);
    chk("frag_pulses", byte_q.size(), 2);
    if (byte_q.size() == 2) chk("frag_second", byte_q[1], {1'b0, 8'hAE});
    chk("frag_display_on", display_on, 1'b0);
`ifdef OLED_RX_FRAME_ERR_EN
    chk("frag_frame_err", frame_err, 1'b1);
`endif
    clear_q();

    // rst_n mid-byte: partial byte discarded, next byte lands at address 0.
    cs_low();
    send_byte(8'hAF, 0); send_byte(8'h81, 0); send_byte(8'h33, 0);
    send_byte(8'h20, 0); send_byte(8'h00, 0);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1);
    wclk(6);
    chk("pre_rst_on", display_on, 1'b1);
    chk("pre_rst_ct", contrast, 8'h33);
    send_bits(8'hA5, 1, 4);
    rst_n = 1'b0; wclk(2); rst_n = 1'b1; wclk(1);
    check_reset("midbyte");
    wclk(4); m_reset(); clear_q();
    send_byte(8'h5A, 1);
    cs_high(); wclk(6);
    chk("after_rst_count", fb_q.size(), 1);
    if (fb_q.size() == 1) chk("after_rst_fb", fb_q[0], {10'd0, 8'h5A});

    // Display reset pin.
    cs_low(); send_byte(8'hAF, 0); send_byte(8'h81, 0); send_byte(8'hC3, 0); cs_high();
    wclk(6);
    chk("pre_res_ct", contrast, 8'hC3);
    res_n = 1'b0; wclk(4); res_n = 1'b1; wclk(1);
    check_reset("res_n");
    wclk(4); m_reset(); clear_q();

    // Randomised command/data mix against the model.
    cs_low();
    for (int i = 0; i < 300; i++) begin
      d = ($urandom_range(0, 99) < 45);
      if (!d && $urandom_range(0, 1) == 1) b = pool[$urandom_range(0, 11)];
      else                                 b = 8'($urandom);
      send_byte(b, d);
      if ($urandom_range(0, 15) == 0) begin cs_high(); cs_low(); end
    end
    cs_high(); wclk(8);
    chk("rand_pulses", byte_q.size(), 300);
    compare_fb("rand");
    chk("rand_on", display_on,  m_on);
    chk("rand_ct", contrast,    m_ct);
    chk("rand_cp", charge_pump, m_cp);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
